// File: rtl/separador_numeros.sv
// Binary-to-ASCII decimal transmitter: double-dabble conversion, then MSD-first digit stream plus terminator.
// Optional signed mode (leading '-') is enabled by defining SEPARADOR_SIGNO_EN.
module separador_numeros #(
  parameter int          WIDTH      = 32,
  parameter int          DIGITS     = 10,
  parameter logic [7:0]  TERMINATOR = 8'h0A
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] valor,
  input  logic             start,
  input  logic             tx_done,
  output logic [7:0]       dato,
  output logic             tx_start,
  output logic             busy,
  output logic             fin
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CONVERT,
    S_SKIP,
`ifdef SEPARADOR_SIGNO_EN
    S_SIGN,
`endif
    S_SEND,
    S_WAIT,
    S_TERM,
    S_WAIT_T,
    S_DONE
  } state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    bin;
  logic [4*DIGITS-1:0] bcd, bcd_adj;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       index, index_next, top;
  logic [3:0]          next_digit;
  logic                ack;
`ifdef SEPARADOR_SIGNO_EN
  logic                negative;
  logic                sign_wait;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    bcd_adj = bcd;
    top     = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      if (bcd[4*d +: 4] != 4'd0) top = IW'(d);
    end
  end

  always_comb begin
    state_next = state;
    index_next = index;
    case (state)
      S_IDLE:    if (start) state_next = S_CONVERT;
      S_CONVERT: if (cnt == CW'(WIDTH - 1)) state_next = S_SKIP;
      S_SKIP: begin
        index_next = top;
`ifdef SEPARADOR_SIGNO_EN
        state_next = negative ? S_SIGN : S_SEND;
`else
        state_next = S_SEND;
`endif
      end
`ifdef SEPARADOR_SIGNO_EN
      S_SIGN:    state_next = S_WAIT;
`endif
      S_SEND:    state_next = S_WAIT;
      // tx_done is acknowledged one cycle before acting on it, giving a 2-cycle done-to-start gap
      S_WAIT: begin
        if (ack) begin
`ifdef SEPARADOR_SIGNO_EN
          if (sign_wait) state_next = S_SEND;
          else
`endif
          if (index != '0) begin
            index_next = index - IW'(1);
            state_next = S_SEND;
          end else begin
            state_next = S_TERM;
          end
        end
      end
      S_TERM:    state_next = S_WAIT_T;
      S_WAIT_T:  if (tx_done) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    next_digit = bcd[4*index_next +: 4];
  end

  assign tx_start = (state == S_SEND) || (state == S_TERM)
`ifdef SEPARADOR_SIGNO_EN
                    || (state == S_SIGN)
`endif
                    ;
  assign busy = (state != S_IDLE);
  assign fin  = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      index <= '0;
      ack   <= 1'b0;
      dato  <= '0;
`ifdef SEPARADOR_SIGNO_EN
      negative  <= 1'b0;
      sign_wait <= 1'b0;
`endif
    end else begin
      state <= state_next;
      index <= index_next;
      ack   <= (state == S_WAIT) && !ack && tx_done;

      case (state)
        S_IDLE: if (start) begin
          bcd <= '0;
          cnt <= '0;
`ifdef SEPARADOR_SIGNO_EN
          negative <= valor[WIDTH-1];
          bin      <= valor[WIDTH-1] ? -valor : valor;
`else
          bin      <= valor;
`endif
        end
        S_CONVERT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt + CW'(1);
        end
        default: ;
      endcase

      // dato is loaded on entry to a transmit state and then held until the next byte
      case (state_next)
        S_SEND: dato <= 8'h30 + {4'h0, next_digit};
        S_TERM: dato <= TERMINATOR;
`ifdef SEPARADOR_SIGNO_EN
        S_SIGN: dato <= 8'h2D;
`endif
        default: ;
      endcase

`ifdef SEPARADOR_SIGNO_EN
      if (state == S_SIGN)           sign_wait <= 1'b1;
      else if (state == S_WAIT && ack) sign_wait <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_separador_numeros.sv
// Self-checking bench for separador_numeros: directed and random values against a decimal-string reference model.
module tb_separador_numeros;

  localparam int WIDTH = 32;
  localparam int FIRST_LAT = WIDTH + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] valor;
  logic             start;
  logic             tx_done;
  logic [7:0]       dato;
  logic             tx_start;
  logic             busy;
  logic             fin;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  separador_numeros #(.WIDTH(WIDTH), .DIGITS(10), .TERMINATOR(8'h0A)) dut (
    .clk(clk), .reset(reset), .valor(valor), .start(start), .tx_done(tx_done),
    .dato(dato), .tx_start(tx_start), .busy(busy), .fin(fin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal text of the value, optional leading '-', then newline.
  function automatic void build_expected(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] mag;
    longint unsigned  m;
    logic [7:0]       digits[$];
    mag = v;
    exp_q.delete();
`ifdef SEPARADOR_SIGNO_EN
    if (v[WIDTH-1]) begin
      exp_q.push_back(8'h2D);
      mag = -v;
    end
`endif
    m = longint'(mag);
    do begin
      digits.push_front(8'h30 + 8'(m % 10));
      m = m / 10;
    end while (m != 0);
    foreach (digits[k]) exp_q.push_back(digits[k]);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic do_request(input logic [WIDTH-1:0] v, input int gap, input bit disturb, input int abort_after);
    int         lat;
    int         bad;
    logic [7:0] held;
    build_expected(v);
    @(negedge clk); valor = v; start = 1'b1;
    @(negedge clk); start = 1'b0; valor = $urandom; lat = 1;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < exp_q.size(); i++) begin
      while (!tx_start && lat < 400) begin
        start = disturb && (i == 0) && (lat == 5);
        valor = $urandom;
        @(negedge clk); lat++;
      end
      start = 1'b0;
      if (!tx_start) begin
        check($sformatf("timeout_byte%0d", i), 32'(tx_start), 32'd1);
        return;
      end
      check($sformatf("latency_byte%0d", i), 32'(lat), (i == 0) ? 32'(FIRST_LAT) : 32'd2);
      check($sformatf("dato_byte%0d", i), 32'(dato), 32'(exp_q[i]));
      held = dato;
      if (abort_after == i) begin
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort_tx_start", 32'(tx_start), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fin", 32'(fin), 32'd0);
        return;
      end
      bad = 0;
      for (int j = 0; j < gap; j++) begin
        @(negedge clk);
        if (tx_start || dato !== held || fin || !busy) bad++;
        start = disturb && (j == gap / 2);
        valor = $urandom;
      end
      start = 1'b0;
      check($sformatf("quiet_wait_byte%0d", i), 32'(bad), 32'd0);
      tx_done = 1'b1;
      @(negedge clk); tx_done = 1'b0; lat = 1;
    end
    check("fin_pulse", 32'(fin), 32'd1);
    check("busy_in_fin", 32'(busy), 32'd1);
    start = disturb; valor = $urandom;
    @(negedge clk); start = 1'b0;
    check("fin_cleared", 32'(fin), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tx_done = 1'b0; valor = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_dato", 32'(dato), 32'd0);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_fin", 32'(fin), 32'd0);

    do_request(32'd0, 10, 1'b0, -1);
    do_request(32'd1234, 10, 1'b0, -1);
    do_request(32'hFFFF_FFFF, 3, 1'b0, -1);
`ifdef SEPARADOR_SIGNO_EN
    do_request(32'h8000_0000, 2, 1'b0, -1);
    do_request(-32'sd7, 4, 1'b0, -1);
`endif
    do_request(32'd98765, 200, 1'b1, -1);
    do_request(32'd1234, 6, 1'b0, 1);
    do_request(32'd56, 5, 1'b0, -1);

    for (int r = 0; r < 6; r++)
      do_request($urandom >> $urandom_range(0, 31), $urandom_range(1, 8), 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/separador_numeros.md
# separador_numeros

Transmit-side counterpart of the digit-concatenating receiver block. It takes a 32-bit binary result and converts it to decimal with a double-dabble shift/add-3 engine. It then streams the digits, most significant first, as ASCII bytes to the UART transmitter, followed by a terminator byte. It sits between the arithmetic/result logic and the UART TX core and uses a one-byte-at-a-time start/done handshake.

## Interface
- `WIDTH`, 32: bit width of `valor`.
- `DIGITS`, 10: BCD digit count; must be ≥ ceil(WIDTH·log10 2).
- `TERMINATOR`, 8'h0A: byte sent after the last digit.

- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `valor` in WIDTH: number to send; sampled only on an accepted `start`.
- `start` in 1: request; accepted only in IDLE.
- `tx_done` in 1: one-cycle pulse from UART TX when the current byte has finished.
- `dato` out 8: byte for UART TX; valid while `tx_start` is high; held until the next byte.
- `tx_start` out 1: one-cycle pulse; UART TX latches `dato`.
- `busy` out 1: high from the cycle after `start` is accepted through the `fin` cycle.
- `fin` out 1: one-cycle pulse after the terminator's `tx_done`.

## Operation
- **Reset values:** `dato`=0, `tx_start`=0, `busy`=0, `fin`=0. State is IDLE, the BCD register is 0, and the digit index is 0.
- **IDLE:**
  - If `start`=1, latch `valor` (or its magnitude, see Configuration) into the shift register, clear the BCD register, record the sign, and go to CONVERT.
  - `start` in any other state is ignored.
- **CONVERT:**
  - Runs exactly WIDTH cycles.
  - Each cycle, add 3 to every BCD nibble ≥5, then shift {BCD, bin} left by 1.
  - Then go to SKIP.
- **SKIP (1 cycle):**
  - Index = highest nonzero digit.
  - If all digits are zero, index = 0, so a single "0" is sent.
  - Go to SIGN if the number is negative (macro enabled); otherwise go to SEND.
- **SIGN:** `dato`=8'h2D, `tx_start` pulsed, then WAIT with next = SEND.
- **SEND:**
  - `dato` = 8'h30 + BCD[index], `tx_start`=1 for one cycle.
  - Go to WAIT.
- **WAIT:**
  - Hold `dato`; `tx_start`=0.
  - On `tx_done`: if index>0, decrement and go to SEND; if index=0, go to TERM.
  - The wait is unbounded; there is no timeout.
- **TERM:** `dato`=TERMINATOR, `tx_start` pulse, go to WAIT_T.
- **WAIT_T:** on `tx_done`, go to DONE.
- **DONE (1 cycle):** `fin`=1, `busy`=1, next state IDLE.
- **`tx_done` sampling:**
  - `tx_done` is sampled only in WAIT, SIGN-wait and WAIT_T.
  - A `tx_done` in the same cycle as `tx_start` is ignored; the UART cannot finish in zero cycles.
- **Reset mid-operation:** immediately returns to IDLE with all outputs at reset values. A byte already latched by the UART completes there; this block does not resend it.
- **`start` in the `fin` cycle:** ignored. A new `start` is accepted from the next cycle (IDLE) onward.

## Timing
- `start` is sampled at edge E.
- CONVERT occupies edges E+1..E+WIDTH; SKIP is at E+WIDTH+1.
- First `tx_start` is high in the cycle after edge E+WIDTH+1, i.e. WIDTH+2 cycles after the start cycle.
- Each `tx_done` produces the next `tx_start` exactly 2 cycles later (one cycle in WAIT plus the SEND cycle).
- `fin` is high in the cycle 1 after the terminator's `tx_done` is sampled.
- Bytes per request = digits + 1, plus 1 if a sign is sent.

## Configuration
- **`SEPARADOR_SIGNO_EN` defined:**
  - `valor` is two's complement.
  - If MSB=1, the magnitude = −`valor` (computed in WIDTH bits, unsigned).
  - The most negative value, 2^(WIDTH−1), is represented correctly.
  - '-' (8'h2D) is sent before the digits.
- **`SEPARADOR_SIGNO_EN` undefined:**
  - `valor` is unsigned.
  - The SIGN state is not synthesized.
  - '-' is never sent.

## Test plan
- Reset, `valor`=0, `start` pulse, `tx_done` 10 cycles after each `tx_start` → bytes 0x30, 0x0A; one `fin` pulse; `busy` drops after `fin`.
- `valor`=1234 → bytes 0x31,0x32,0x33,0x34,0x0A. First `tx_start` 34 cycles after the start cycle; each next `tx_start` 2 cycles after each `tx_done`.
- Macro undefined, `valor`=32'hFFFFFFFF → "4294967295\n" (11 bytes).
- Macro defined, `valor`=32'h80000000 → "-2147483648\n".
- Macro defined, `valor`=−7 → 0x2D, 0x37, 0x0A.
- `start` re-pulsed during CONVERT and during WAIT, and `tx_done` withheld for 200 cycles → no new capture; `dato` stable; no extra `tx_start`; sequence resumes correctly.
- `reset` asserted in WAIT after the second digit of 1234 → next cycle: `tx_start`=0, `busy`=0, `fin`=0. A following `start` with 56 → exactly 0x35, 0x36, 0x0A.
